tow_press_gen: RTL and testbench

//  Producer side of the tug-of-war playfield L/R interface: turns raw active-low

---
 rtl/tow_press_gen.sv | 91 +++++++++
 tb/tb_tow_press_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_press_gen.sv
// Tug-of-war press generator: synchronizes raw player keys and an optional LFSR
// computer opponent into clean single-cycle L/R press pulses for the light chain.
module tow_press_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int CPU_DIV     = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key_l_n,
  input  logic       key_r_n,
  input  logic       cpu_en,
  input  logic [9:0] cpu_level,
  input  logic       freeze,
  output logic       L,
  output logic       R
);

  localparam int DIV_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  logic [SYNC_STAGES-1:0] sync_l;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] sync_en;
  logic                   key_l_q;
  logic                   key_r_q;
  logic                   prev_l;
  logic                   prev_r;
  logic                   cpu_en_q;
  logic [DIV_W-1:0]       div_q;
  logic [9:0]             lfsr_q;
  logic                   cpu_req;

  logic cpu_en_sync;
  logic src_r;
  logic mode_chg;
  logic pulse_l;
  logic pulse_r;
  logic div_last;

  assign cpu_en_sync = sync_en[SYNC_STAGES-1];
  assign div_last    = (div_q == DIV_W'(CPU_DIV - 1));

  // cpu_req is already a registered, clock-domain signal, so it bypasses the key pipeline
  assign src_r    = cpu_en_sync ? cpu_req : key_r_q;
  assign mode_chg = cpu_en_sync ^ cpu_en_q;
  assign pulse_l  = key_l_q & ~prev_l;
  assign pulse_r  = src_r & ~prev_r & ~mode_chg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_l   <= '0;
      sync_r   <= '0;
      sync_en  <= '0;
      key_l_q  <= 1'b0;
      key_r_q  <= 1'b0;
      prev_l   <= 1'b0;
      prev_r   <= 1'b0;
      cpu_en_q <= 1'b0;
      L        <= 1'b0;
      R        <= 1'b0;
    end else begin
      sync_l   <= {sync_l[SYNC_STAGES-2:0], ~key_l_n};
      sync_r   <= {sync_r[SYNC_STAGES-2:0], ~key_r_n};
      sync_en  <= {sync_en[SYNC_STAGES-2:0], cpu_en};
      key_l_q  <= sync_l[SYNC_STAGES-1];
      key_r_q  <= sync_r[SYNC_STAGES-1];
      prev_l   <= key_l_q;
      prev_r   <= src_r;
      cpu_en_q <= cpu_en_sync;
      // history keeps tracking during freeze so a held key never fires on release
      L        <= pulse_l & ~freeze;
      R        <= pulse_r & ~freeze;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q   <= '0;
      lfsr_q  <= 10'h001;
      cpu_req <= 1'b0;
    end else begin
      if (div_last) begin
        div_q  <= '0;
        lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      end else begin
        div_q  <= div_q + DIV_W'(1);
      end
      cpu_req <= (lfsr_q < cpu_level);
    end
  end

endmodule

// File: tb/tb_tow_press_gen.sv
// Directed self-checking bench for tow_press_gen: key latency, simultaneous presses,
// computer opponent, freeze, cpu mode switching and reset in mid-press.
module tb_tow_press_gen;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       key_l_n;
  logic       key_r_n;
  logic       cpu_en;
  logic [9:0] cpu_level;
  logic       freeze;
  logic       L;
  logic       R;

  int errors = 0;
  int checks = 0;

  logic [9:0] mq;
  logic       mreq;

  tow_press_gen #(.SYNC_STAGES(2), .CPU_DIV(1)) dut (
    .Clock(Clock), .Reset(Reset), .key_l_n(key_l_n), .key_r_n(key_r_n),
    .cpu_en(cpu_en), .cpu_level(cpu_level), .freeze(freeze), .L(L), .R(R)
  );

  always #5 Clock = ~Clock;

  // independent reference of the opponent: LFSR stepping every cycle and its compare
  always @(posedge Clock) begin
    if (Reset) begin
      mq   <= 10'h001;
      mreq <= 1'b0;
    end else begin
      mq   <= {mq[8:0], mq[9] ^ mq[6]};
      mreq <= (mq < cpu_level);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1; cpu_en = 1'b0;
    cpu_level = 10'h000; freeze = 1'b0;
    tick(); tick();
    checks++;
    if (L !== 1'b0 || R !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: L=%b R=%b required 0 0", L, R);
    end
    checks++;
    if (dut.lfsr_q !== 10'h001) begin
      errors++; $display("FAIL reset_lfsr: got %h required 001", dut.lfsr_q);
    end
    Reset = 1'b0;
    tick(); tick(); tick();
  endtask

  // key first sampled at edge k; L must be high only after edge k+3
  task automatic test_single_press();
    logic exp_l;
    key_l_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_l = (e == 3);
      checks++;
      if (L !== exp_l || R !== 1'b0) begin
        errors++;
        $display("FAIL single_press edge k+%0d: L=%b R=%b required L=%b R=0", e, L, R, exp_l);
      end
    end
    key_l_n = 1'b1;
    for (int e = 0; e < 6; e++) tick();
  endtask

  task automatic test_simultaneous();
    for (int rep = 0; rep < 2; rep++) begin
      int nl = 0;
      int nr = 0;
      key_l_n = 1'b0; key_r_n = 1'b0;
      for (int e = 0; e < 5; e++) begin
        tick();
        if (e == 3) begin
          checks++;
          if (L !== 1'b1 || R !== 1'b1) begin
            errors++;
            $display("FAIL simul_same_cycle rep%0d: L=%b R=%b required 1 1", rep, L, R);
          end
        end
        nl += int'(L); nr += int'(R);
      end
      key_l_n = 1'b1; key_r_n = 1'b1;
      for (int e = 0; e < 5; e++) begin
        tick();
        nl += int'(L); nr += int'(R);
      end
      checks++;
      if (nl != 1 || nr != 1) begin
        errors++;
        $display("FAIL simul_count rep%0d: L pulses=%0d R pulses=%0d required 1 1", rep, nl, nr);
      end
    end
  endtask

  task automatic test_cpu();
    int nr = 0;
    int nmodel = 0;
    int diff;
    logic mreq_prev;
    cpu_en = 1'b1; cpu_level = 10'h000;
    for (int e = 0; e < 10; e++) tick();
    for (int e = 0; e < 2000; e++) begin
      key_r_n = ((e / 3) % 2 == 0);
      tick();
      nr += int'(R);
    end
    key_r_n = 1'b1;
    checks++;
    if (nr != 0) begin
      errors++; $display("FAIL cpu_level0: R pulses=%0d required 0", nr);
    end
    checks++;
    if (dut.lfsr_q !== mq) begin
      errors++; $display("FAIL lfsr_sequence: got %h required %h", dut.lfsr_q, mq);
    end
    cpu_level = 10'h200;
    for (int e = 0; e < 10; e++) tick();
    nr = 0;
    mreq_prev = mreq;
    for (int e = 0; e < 2000; e++) begin
      tick();
      nr += int'(R);
      if (mreq && !mreq_prev) nmodel++;
      mreq_prev = mreq;
    end
    diff = (nr > nmodel) ? nr - nmodel : nmodel - nr;
    checks++;
    if (diff * 20 > nmodel || nmodel == 0) begin
      errors++; $display("FAIL cpu_level200: R pulses=%0d model rises=%0d required within 5%%", nr, nmodel);
    end
  endtask

  task automatic test_freeze();
    int nl = 0;
    key_l_n = 1'b0; freeze = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick(); nl += int'(L);
    end
    freeze = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick(); nl += int'(L);
    end
    checks++;
    if (nl != 0) begin
      errors++; $display("FAIL freeze_held: L pulses=%0d required 0", nl);
    end
    key_l_n = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    nl = 0;
    key_l_n = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick(); nl += int'(L);
    end
    key_l_n = 1'b1;
    checks++;
    if (nl != 1) begin
      errors++; $display("FAIL freeze_repress: L pulses=%0d required 1", nl);
    end
  endtask

  // level 3FF keeps cpu_req high except at q=3FF; start just after that state so it cannot recur
  task automatic test_mode_switch();
    int nr = 0;
    int budget = 0;
    cpu_level = 10'h3FF; cpu_en = 1'b1; key_r_n = 1'b1;
    while (mq !== 10'h3FF && budget < 1100) begin
      tick(); budget++;
    end
    checks++;
    if (mq !== 10'h3FF) begin
      errors++; $display("FAIL mode_wait: model q=%h never reached 3ff within budget", mq);
    end
    for (int e = 0; e < 10; e++) tick();
    cpu_en = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick(); nr += int'(R);
    end
    checks++;
    if (nr != 0) begin
      errors++; $display("FAIL mode_1to0: R pulses=%0d required 0", nr);
    end
    nr = 0;
    cpu_en = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick(); nr += int'(R);
    end
    checks++;
    if (nr != 0) begin
      errors++; $display("FAIL mode_0to1: R pulses=%0d required 0", nr);
    end
  endtask

  task automatic test_reset_mid_press();
    logic exp_r;
    cpu_en = 1'b0; cpu_level = 10'h000;
    for (int e = 0; e < 6; e++) tick();
    key_r_n = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (R !== 1'b0 || dut.lfsr_q !== 10'h001) begin
      errors++;
      $display("FAIL midpress_reset: R=%b lfsr=%h required R=0 lfsr=001", R, dut.lfsr_q);
    end
    Reset = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp_r = (e == 3);
      checks++;
      if (R !== exp_r) begin
        errors++;
        $display("FAIL midpress_repulse edge k+%0d: R=%b required %b", e, R, exp_r);
      end
    end
    key_r_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_cpu();
    test_freeze();
    test_mode_switch();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
